// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch resolution and bimodal prediction unit for the RV32I pipeline.
// It sits directly after the branch comparator in EX and does five jobs:
//   - supplies the signed/unsigned compare select to the comparator;
//   - turns the equal/less flags and funct3 into a taken decision;
//   - checks that decision against the prediction made at fetch time;
//   - keeps a table of 2-bit saturating counters, read by IF and trained by EX;
//   - issues a registered redirect on a mispredict and counts branches and
//     mispredicts.
//
// Parameters
//   BHT_ENTRIES : number of 2-bit counters (power of two, >= 2)
//   IDX_W       : table index width; the index is pc[IDX_W+1:2]
//
// Ports
//   i_clk, i_reset        : clock, asynchronous active-low reset
//   i_if_pc               : fetch PC to look up
//   o_if_pred_taken       : prediction for i_if_pc (combinational table read)
//   i_ex_valid            : EX holds a live (non-flushed) instruction
//   i_ex_is_branch        : the EX instruction is a conditional branch
//   i_ex_funct3           : branch funct3
//   o_br_un               : unsigned-compare select to the comparator
//   i_br_equal, i_br_less : comparator flags
//   i_ex_pc, i_ex_target  : PC of the branch and its taken target
//   i_ex_pred_taken       : prediction carried down the pipe with the branch
//   o_ex_taken            : resolved direction (combinational)
//   o_ex_illegal          : branch with a reserved funct3 (010/011)
//   o_redirect_valid      : one-cycle mispredict redirect pulse (registered)
//   o_redirect_pc         : correct next PC for the redirect (registered)
//   o_br_count            : number of resolved legal branches
//   o_mis_count           : number of mispredicts
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_if_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [2:0]  i_ex_funct3,
  output logic        o_br_un,
  input  logic        i_br_equal,
  input  logic        i_br_less,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  output logic        o_ex_taken,
  output logic        o_ex_illegal,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mis_count
);

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Saturating 2-bit counter training step.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_STRONG_T) begin
        nxt = ctr + 2'b01;
      end else begin
        nxt = ctr;
      end
    end else begin
      if (ctr != CTR_STRONG_NT) begin
        nxt = ctr - 2'b01;
      end else begin
        nxt = ctr;
      end
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] br_count_q;
  logic [31:0] mis_count_q;

  // Next-state values
  logic [1:0]  bht_entry_d;
  logic        redirect_valid_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] br_count_d;
  logic [31:0] mis_count_d;

  // Combinational helpers
  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             br_active_s;
  logic             dir_taken_s;
  logic             dir_illegal_s;
  logic             ex_taken_s;
  logic             ex_illegal_s;
  logic             res_s;
  logic             mis_s;
  logic [31:0]      ex_pc_plus4_s;
  logic             unused_pc_bits_s;

  assign if_idx_s = i_if_pc[IDX_W+1:2];
  assign ex_idx_s = i_ex_pc[IDX_W+1:2];

  // PC bits outside the index window only matter for aliasing, which is allowed.
  assign unused_pc_bits_s = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE; it is passed through ungated.
  assign o_br_un = i_ex_funct3[1];

  // Raw direction decode from funct3 and the comparator flags.
  always_comb begin
    dir_taken_s   = 1'b0;
    dir_illegal_s = 1'b0;
    case (i_ex_funct3)
      3'b000: dir_taken_s = i_br_equal;          // BEQ
      3'b001: dir_taken_s = ~i_br_equal;         // BNE
      3'b100: dir_taken_s = i_br_less;           // BLT
      3'b101: dir_taken_s = ~i_br_less;          // BGE
      3'b110: dir_taken_s = i_br_less;           // BLTU
      3'b111: dir_taken_s = ~i_br_less;          // BGEU
      3'b010,
      3'b011: begin
        dir_taken_s   = 1'b0;
        dir_illegal_s = 1'b1;
      end
      default: begin
        dir_taken_s   = 1'b0;
        dir_illegal_s = 1'b0;
      end
    endcase
  end

  // Qualify the decode with a live branch and derive resolve / mispredict.
  always_comb begin
    br_active_s   = i_ex_valid & i_ex_is_branch;
    ex_taken_s    = br_active_s & dir_taken_s;
    ex_illegal_s  = br_active_s & dir_illegal_s;
    res_s         = br_active_s & ~ex_illegal_s;
    mis_s         = res_s & (ex_taken_s ^ i_ex_pred_taken);
    ex_pc_plus4_s = i_ex_pc + 32'd4;  // wraps modulo 2^32
  end

  assign o_ex_taken   = ex_taken_s;
  assign o_ex_illegal = ex_illegal_s;

  // Fetch-side lookup reads the registered table only, so a same-cycle update
  // of the same index is not visible until the following cycle.
  assign o_if_pred_taken = bht_q[if_idx_s][1];

  // Next-state for the trained entry, redirect and statistics.
  always_comb begin
    bht_entry_d      = ctr_train(bht_q[ex_idx_s], ex_taken_s);
    redirect_valid_d = mis_s;
    redirect_pc_d    = redirect_pc_q;
    br_count_d       = br_count_q;
    mis_count_d      = mis_count_q;
    if (mis_s) begin
      redirect_pc_d = ex_taken_s ? i_ex_target : ex_pc_plus4_s;
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
    if (res_s) begin
      br_count_d = br_count_q + 32'd1;
    end else begin
      br_count_d = br_count_q;
    end
    if (mis_s) begin
      mis_count_d = mis_count_q + 32'd1;
    end else begin
      mis_count_d = mis_count_q;
    end
  end

  // Counter table: reset to weak not-taken, train only the resolving entry.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_WEAK_NT;
      end
    end else if (res_s) begin
      bht_q[ex_idx_s] <= bht_entry_d;
    end
  end

  // Redirect and statistics registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      br_count_q       <= 32'd0;
      mis_count_q      <= 32'd0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      mis_count_q      <= mis_count_d;
    end
  end

  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_br_count       = br_count_q;
  assign o_mis_count      = mis_count_q;

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Branch resolution and prediction unit for the RV32I core, sitting directly downstream of the branch comparator in EX. It derives `o_br_un` for the comparator, turns the equal/less flags plus `funct3` into a taken decision, and checks that decision against the fetch-time prediction. It holds a table of 2-bit saturating counters that serves predictions to IF and is trained by EX. It issues a registered redirect to the PC mux on a mispredict and keeps branch and mispredict statistics counters.

## Interface

**Parameters**
- `BHT_ENTRIES`, default 64: number of 2-bit counters. Must be a power of 2, ≥ 2.
- `IDX_W`, default `$clog2(BHT_ENTRIES)`: index width. Index is `pc[IDX_W+1:2]`.

**Ports**
- `i_clk`, in, 1: the single clock.
- `i_reset`, in, 1: reset is asynchronous and active-low.
- `i_if_pc`, in, 32: PC of the instruction currently being fetched.
- `o_if_pred_taken`, out, 1: prediction for `i_if_pc`.
- `i_ex_valid`, in, 1: EX holds a live (non-flushed) instruction.
- `i_ex_is_branch`, in, 1: the EX instruction is a conditional branch (opcode 1100011).
- `i_ex_funct3`, in, 3: branch `funct3`.
- `o_br_un`, out, 1: unsigned-compare select to the comparator. Equals `i_ex_funct3[1]`.
- `i_br_equal`, in, 1: equal flag from the comparator.
- `i_br_less`, in, 1: less flag from the comparator.
- `i_ex_pc`, in, 32: PC of the EX branch.
- `i_ex_target`, in, 32: branch target (`pc + imm`), computed elsewhere.
- `i_ex_pred_taken`, in, 1: prediction carried down the pipe with the branch.
- `o_ex_taken`, out, 1: resolved direction (combinational).
- `o_ex_illegal`, out, 1: branch with `funct3` 010 or 011.
- `o_redirect_valid`, out, 1: registered mispredict redirect.
- `o_redirect_pc`, out, 32: registered correct next PC.
- `o_br_count`, out, 32: resolved legal branches.
- `o_mis_count`, out, 32: mispredicts.

## Operation

**Resolve qualifier**
- `res = i_ex_valid & i_ex_is_branch & ~o_ex_illegal`.

**Direction decode (combinational)**
- BEQ (000): taken = `eq`.
- BNE (001): taken = `~eq`.
- BLT (100) and BLTU (110): taken = `less`.
- BGE (101) and BGEU (111): taken = `~less`.
- 010 and 011: `o_ex_taken=0`, `o_ex_illegal=1`. No table update, no count, no redirect.
- `o_ex_taken` and `o_ex_illegal` are forced to 0 when `i_ex_valid & i_ex_is_branch` is 0.

**BHT**
- Each entry is a 2-bit counter. Encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- `o_if_pred_taken` is the MSB of `bht[i_if_pc[IDX_W+1:2]]`. It is a combinational read of the registered state.
- On `res`, at the clock edge, `bht[i_ex_pc[IDX_W+1:2]]` is updated:
  - taken: increment, saturating at 11;
  - not taken: decrement, saturating at 00.
- No other entry changes.

**Mispredict**
- Condition: `mis = res & (o_ex_taken ^ i_ex_pred_taken)`.
- On the clock edge: `o_redirect_valid <= mis`.
- When `mis` is 1: `o_redirect_pc <= o_ex_taken ? i_ex_target : i_ex_pc + 4`. The addition is 32-bit and wraps modulo 2^32.
- `o_redirect_pc` holds its value when `mis` is 0.

**Statistics**
- `o_br_count` increments on `res`.
- `o_mis_count` increments on `mis`.
- Both wrap from 0xFFFFFFFF to 0.

## Timing

**Reset** (`i_reset=0`, immediate, asynchronous)
- All BHT entries = 01.
- `o_redirect_valid=0`, `o_redirect_pc=0`, `o_br_count=0`, `o_mis_count=0`.
- Consequently `o_if_pred_taken=0` during and after reset.
- Reset asserted mid-operation discards any pending redirect and update. No edge-triggered state changes while `i_reset=0`.

**Latency**
- Prediction and resolve outputs: 0 cycles (combinational).
- BHT update: visible to lookup on the cycle after the resolve edge.
- Redirect: exactly 1 cycle after the EX resolve cycle. Pulse width is 1 cycle per mispredict.

**Boundary behaviour**
- Simultaneous lookup and update of the same index: the lookup returns the pre-update value. There is no bypass.
- Back-to-back mispredicts on consecutive cycles give `o_redirect_valid` high on both cycles, each with its own PC. Upstream is responsible for flushing (deasserting `i_ex_valid`) after a redirect.
- Aliasing between PCs sharing an index is permitted and expected.
- `i_ex_pc+4` at 0xFFFFFFFC wraps to 0x00000000.

## Test plan

- **Reset:** after reset release, `i_if_pc=0x100` → `o_if_pred_taken=0`, all counters 0, `o_redirect_valid=0`.
- **Decode and `o_br_un`:** BGEU with `eq=0`, `less=1` → `o_ex_taken=0`, `o_br_un=1`. BLT with `less=1` → taken, `o_br_un=0`. `funct3=011` → `o_ex_illegal=1`, counts unchanged.
- **Training:** BEQ at PC 0x40, `eq=1`, pred 0, on two consecutive cycles.
  - Cycle N+1: `o_redirect_valid=1`, `o_redirect_pc=target 0x80`.
  - Counter goes 01→10→11.
  - From cycle N+1, `i_if_pc=0x40` gives pred 1.
  - `o_br_count=2`, `o_mis_count=2`.
- **Same-index collision:** update of index 5 and lookup of PC 0x14 in the same cycle → old MSB returned; new MSB the next cycle.
- **Not-taken mispredict at wrap:** `i_ex_pc=0xFFFFFFFC`, pred 1, not taken → `o_redirect_pc=0x00000000` one cycle later.
- **Mid-flight reset:** assert `i_reset=0` in the cycle between a mispredict and its redirect edge → `o_redirect_valid` stays 0, counters cleared, table back to 01.
